// File: rtl/mem_arbiter_if.sv
// Requester and Memory-pin bundle for mem_arbiter: two request ports plus the
// single-port Memory address/data/wr/cs/o pins.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_a;
  logic              ack_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              busy;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wr;
  logic              mem_cs;
  logic [DATA_W-1:0] mem_o;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_o,
    output ack_a, ack_b, rdata_a, rdata_b, busy,
           mem_address, mem_data, mem_wr, mem_cs
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  ack_a, ack_b, rdata_a, rdata_b, busy
  );

  modport memory (
    input  mem_address, mem_data, mem_wr, mem_cs,
    output mem_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port Memory: one
// transaction at a time, registered Memory pins, one-cycle ack per grant.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic          i_clock,
  input logic          i_reset_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_grant_b;
  logic              r_last_grant_b;
  logic              r_ack_a;
  logic              r_ack_b;
  logic              r_busy;
  logic              r_mem_wr;
  logic              r_mem_cs;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_data;
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;

  logic              w_any_req;
  logic              w_grant_b;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Round-robin pick: on a tie the port that did not win last time is served.
  always_comb begin
    w_any_req = bus.req_a | bus.req_b;
    if (bus.req_a && bus.req_b) begin
      w_grant_b = ~r_last_grant_b;
    end else if (bus.req_b) begin
      w_grant_b = 1'b1;
    end else begin
      w_grant_b = 1'b0;
    end
    if (w_grant_b) begin
      w_sel_we    = bus.we_b;
      w_sel_addr  = bus.addr_b;
      w_sel_wdata = bus.wdata_b;
    end else begin
      w_sel_we    = bus.we_a;
      w_sel_addr  = bus.addr_a;
      w_sel_wdata = bus.wdata_a;
    end
  end

  // Transaction sequencer; the async reset also raises mem_cs mid-access.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= S_IDLE;
      r_grant_b      <= 1'b0;
      r_last_grant_b <= 1'b1;
      r_ack_a        <= 1'b0;
      r_ack_b        <= 1'b0;
      r_busy         <= 1'b0;
      r_mem_wr       <= 1'b0;
      r_mem_cs       <= 1'b1;
      r_mem_address  <= {ADDR_W{1'b0}};
      r_mem_data     <= {DATA_W{1'b0}};
      r_rdata_a      <= {DATA_W{1'b0}};
      r_rdata_b      <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_b      <= w_grant_b;
            r_last_grant_b <= w_grant_b;
            r_mem_wr       <= w_sel_we;
            r_mem_address  <= w_sel_addr;
            r_mem_data     <= w_sel_wdata;
            r_mem_cs       <= 1'b0;
            r_busy         <= 1'b1;
            r_state        <= S_ACCESS;
          end else begin
            r_mem_cs <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_ACCESS: begin
          r_mem_cs <= 1'b1;
          if (r_mem_wr) begin
            r_ack_a <= ~r_grant_b;
            r_ack_b <= r_grant_b;
            r_state <= S_RESP;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (r_grant_b) begin
            r_rdata_b <= bus.mem_o;
            r_ack_b   <= 1'b1;
          end else begin
            r_rdata_a <= bus.mem_o;
            r_ack_a   <= 1'b1;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_ack_a <= 1'b0;
          r_ack_b <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack_a  <= 1'b0;
          r_ack_b  <= 1'b0;
          r_busy   <= 1'b0;
          r_mem_cs <= 1'b1;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_a       = r_ack_a;
  assign bus.ack_b       = r_ack_b;
  assign bus.rdata_a     = r_rdata_a;
  assign bus.rdata_b     = r_rdata_b;
  assign bus.busy        = r_busy;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data    = r_mem_data;
  assign bus.mem_wr      = r_mem_wr;
  assign bus.mem_cs      = r_mem_cs;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural Memory, scoreboard of expected acks,
// a vector table for single transactions and hand-written corner sequences.
module tb_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  logic [7:0] mem [0:255];

  // Memory: write or load o on a rising edge while cs is low
  always @(posedge clk) begin
    if (!bus.mem_cs) begin
      if (bus.mem_wr) mem[bus.mem_address] <= bus.mem_data;
      else            bus.mem_o <= mem[bus.mem_address];
    end
  end

  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   ack_total = 0;
  int   cs_low    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Monitor: count cs-low cycles and match every ack against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!bus.mem_cs) cs_low++;
      if (bus.ack_a || bus.ack_b) begin
        ack_total++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack got a=%0b b=%0b required none", bus.ack_a, bus.ack_b);
        end else begin
          e = sb.pop_front();
          if (bus.ack_a && bus.ack_b) begin
            errors++;
            $display("FAIL dual_ack got both required only %s", e.port ? "B" : "A");
          end else if (bus.ack_b != e.port) begin
            errors++;
            $display("FAIL ack_order got %s required %s", bus.ack_b ? "B" : "A", e.port ? "B" : "A");
          end else if (!e.we && ((e.port ? bus.rdata_b : bus.rdata_a) !== e.data)) begin
            errors++;
            $display("FAIL rdata_%s got=%0h required=%0h", e.port ? "b" : "a",
                     e.port ? bus.rdata_b : bus.rdata_a, e.data);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input bit port, input bit val, input bit we,
                         input logic [7:0] addr, input logic [7:0] wdata);
    if (port) begin
      bus.req_b = val; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wdata;
    end else begin
      bus.req_a = val; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wdata;
    end
  endtask

  task automatic do_reset();
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_cs", bus.mem_cs, 1);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_data", bus.mem_data, 0);
    chk("rst_ack_a", bus.ack_a, 0);
    chk("rst_ack_b", bus.ack_b, 0);
    chk("rst_rdata_a", bus.rdata_a, 0);
    chk("rst_rdata_b", bus.rdata_b, 0);
    chk("rst_busy", bus.busy, 0);
  endtask

  // Single transaction: write acks on the 2nd falling edge after drive, read on the 3rd
  task automatic do_txn(input bit port, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp);
    int lat;
    bit seen;
    @(negedge clk);
    sb.push_back('{port, we, exp});
    set_req(port, 1'b1, we, addr, wdata);
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) chk("cs_low_access", bus.mem_cs, 0);
      if (port ? bus.ack_b : bus.ack_a) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    set_req(port, 1'b0, we, addr, wdata);
    chk(we ? "write_latency" : "read_latency", lat, we ? 2 : 3);
  endtask

  task automatic wait_acks(input int target, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      #1;
      if (ack_total >= target) done = 1'b1;
    end
    chk("acks_reached", ack_total, target);
  endtask

  vec_t vecs[8];
  int   base;
  int   cs_start;

  initial begin
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = 8'h00; bus.wdata_a = 8'h00;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = 8'h00; bus.wdata_b = 8'h00;

    vecs[0] = '{1'b0, 1'b1, 8'h10, 8'h5A, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A};
    vecs[2] = '{1'b1, 1'b1, 8'h00, 8'hE7, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hE7};
    vecs[4] = '{1'b0, 1'b1, 8'hFF, 8'h81, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h81};
    vecs[6] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h5A};
    vecs[7] = '{1'b1, 1'b1, 8'h55, 8'h3C, 8'h00};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      if (i == 1) chk("rdata_b_untouched", bus.rdata_b, 0);
    end
    chk("rdata_a_held", bus.rdata_a, 8'h81);
    chk("rdata_b_held", bus.rdata_b, 8'h5A);

    // Reset asserted during a write's ACCESS cycle aborts it without an ack
    do_txn(1'b0, 1'b1, 8'h40, 8'h77, 8'h00);
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 8'h40, 8'h99);
    @(posedge clk);
    #2;
    chk("cs_low_before_abort", bus.mem_cs, 0);
    rst_n = 1'b0;
    #1;
    chk("cs_async_rise", bus.mem_cs, 1);
    chk("busy_async_clear", bus.busy, 0);
    bus.req_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 1'b0, 8'h40, 8'h00, 8'h77);

    // Tie straight out of reset: A first, then B
    do_reset();
    base = ack_total;
    sb.push_back('{1'b0, 1'b1, 8'h00});
    sb.push_back('{1'b1, 1'b1, 8'h00});
    set_req(1'b0, 1'b1, 1'b1, 8'h01, 8'h11);
    set_req(1'b1, 1'b1, 1'b1, 8'h02, 8'h22);
    wait_acks(base + 1, 10);
    bus.req_a = 1'b0;
    wait_acks(base + 2, 10);
    bus.req_b = 1'b0;
    do_txn(1'b0, 1'b0, 8'h01, 8'h00, 8'h11);
    do_txn(1'b1, 1'b0, 8'h02, 8'h00, 8'h22);

    // Fairness: both held high for eight transactions
    do_reset();
    base = ack_total;
    for (int i = 0; i < 8; i++) sb.push_back('{i[0], 1'b1, 8'h00});
    set_req(1'b0, 1'b1, 1'b1, 8'h20, 8'hAA);
    set_req(1'b1, 1'b1, 1'b1, 8'h30, 8'hBB);
    wait_acks(base + 8, 60);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("fair_sb_drained", sb.size(), 0);

    // Full address sweep and cs-low accounting
    cs_start = cs_low;
    for (int a = 0; a < 256; a++) begin
      do_txn(1'b0, 1'b1, 8'(a), 8'(a) ^ 8'hA5, 8'h00);
    end
    for (int a = 0; a < 256; a++) begin
      do_txn(1'b0, 1'b0, 8'(a), 8'h00, 8'(a) ^ 8'hA5);
    end
    #1;
    chk("cs_low_count", cs_low - cs_start, 512);

    // Early drop of req_b with the address changed after grant
    do_txn(1'b0, 1'b1, 8'hFF, 8'hC3, 8'h00);
    @(negedge clk);
    base = ack_total;
    sb.push_back('{1'b1, 1'b0, 8'hC3});
    set_req(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00);
    @(negedge clk);
    bus.req_b  = 1'b0;
    bus.addr_b = 8'h00;
    wait_acks(base + 1, 10);
    chk("early_drop_rdata_b", bus.rdata_b, 8'hC3);
    repeat (4) @(negedge clk);
    #1;
    chk("final_sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer for the 8-bit single-port Memory block. It accepts independent read/write requests from requesters A and B and drives the Memory's address/data/wr/cs pins one transaction at a time. It returns read data and a one-cycle acknowledge to the winning requester. It sits between the Memory instance and its two bus masters and replaces direct tie-offs of the Memory pins.

## Interface
- ADDR_W, 8, address width (matches Memory address)
- DATA_W, 8, data width (matches Memory data/o)
- clock  input  1  single system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_a / req_b  input  1  request from A / B; hold high until ack
- we_a / we_b  input  1  1 = write, 0 = read (same polarity as Memory wr)
- addr_a / addr_b  input  ADDR_W  transaction address
- wdata_a / wdata_b  input  DATA_W  write data
- ack_a / ack_b  output  1  one-cycle completion pulse
- rdata_a / rdata_b  output  DATA_W  read data, valid while ack high, held until next read to that port
- busy  output  1  high in any state other than IDLE
- mem_address  output  ADDR_W  to Memory address
- mem_data  output  DATA_W  to Memory data
- mem_wr  output  1  to Memory wr (1 = write)
- mem_cs  output  1  to Memory cs (active low)
- mem_o  input  DATA_W  from Memory o

## Operation
- Memory contract: on a rising clock edge with mem_cs=0, mem_wr=1, the Memory writes mem_data to mem_address. With mem_cs=0, mem_wr=0, it loads mem_o with the addressed word, valid after that edge. With mem_cs=1, it does nothing.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: if any req is high, grant it and latch we/addr/wdata into mem_wr/mem_address/mem_data. Drive mem_cs=0 and go to ACCESS.
- Arbitration: if only one req is high, that port wins. If both are high, the port that is not last_grant wins. last_grant updates on entering ACCESS.
- ACCESS: lasts exactly one cycle with mem_cs=0. On the next edge, drive mem_cs=1. A write goes to RESP with the granted ack=1. A read goes to CAPTURE.
- CAPTURE: on the next edge, load mem_o into the granted rdata register, assert the granted ack and go to RESP.
- RESP: ack is high for this cycle only. On the next edge, ack=0 and the FSM returns to IDLE.
- Only the granted port's ack and rdata change. The other port's rdata holds its value.
- Address, data and we are sampled only at grant. Later changes, including req dropping before ack, do not affect the transaction, and ack still pulses.
- If req is still high in the IDLE cycle after ack, it is treated as a new request.
- Reset (asynchronous, any state): state=IDLE, mem_cs=1, mem_wr=0, mem_address=0, mem_data=0, ack_a=ack_b=0, rdata_a=rdata_b=0, busy=0, last_grant=B (so A wins the first tie). An aborted transaction produces no ack. mem_cs goes high immediately, so a write in ACCESS is not performed.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Write: req sampled at edge k. mem_cs=0 from k to k+1, and the Memory writes at k+1. ack is high from k+1 to k+2. Latency is 1 cycle to ack. Throughput is one write per 3 cycles.
- Read: req sampled at edge k. mem_cs=0 from k to k+1. CAPTURE runs from k+1 to k+2. rdata and ack are valid from k+2 to k+3. Throughput is one read per 4 cycles.
- mem_cs is low for exactly one cycle per transaction and is never low in IDLE, CAPTURE or RESP.
- Address and data width: ADDR_W and DATA_W pass straight through, with no arithmetic. Addresses 0x00 and 0xFF are treated the same as any other address.
- Continuous requests from both ports alternate strictly A, B, A, B, and neither port waits more than one transaction.

## Test plan
- Reset: hold reset_n=0, then release. Required: mem_cs=1, acks 0, rdata 0, busy 0. Assert reset_n=0 while in ACCESS with we=1. Required: mem_cs rises without a clock edge and the location is unchanged on readback.
- Write then read, port A: write 0x5A to 0x10, then read 0x10. Required: ack_a 2 edges after write grant, then rdata_a=0x5A with ack_a 3 edges after read grant. ack_b stays 0 and rdata_b stays 0.
- Tie: req_a=req_b=1 from reset, A writing 0x11 to 0x01, B writing 0x22 to 0x02. Required: A is served first, then B. Readback gives 0x11 and 0x22.
- Fairness: both ports hold req high for 8 transactions. Required: the ack sequence is A, B, A, B, A, B, A, B.
- Early drop: req_b pulses for one cycle with a read of 0xFF, which was preloaded with 0xC3. Required: ack_b still pulses and rdata_b=0xC3. Changing addr_b after grant has no effect.
- Sweep: A writes addr XOR 0xA5 to addresses 0x00 through 0xFF, then reads them all back. Required: every readback matches, and mem_cs=0 occurs exactly 512 cycles in total.
